// File: rtl/or_op_double.sv
// Two-input OR with a two-stage registered copy, edge pulses and an optional
// saturating high-cycle counter (enabled by defining OR_OP_DOUBLE_STATS_EN).
module or_op_double #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in0,
  input  logic             in1,
  input  logic             cnt_clr,
  output logic             out,
  output logic             out_q,
  output logic             out_q2,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] ones_cnt
);

  logic pipe1_d, pipe1_q;
  logic pipe2_d, pipe2_q;

  // Zero-latency OR; deliberately outside reset so it tracks inputs at all times
  assign out = in0 | in1;

  always_comb begin
    pipe1_d = out;
    pipe2_d = pipe1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe1_q <= 1'b0;
      pipe2_q <= 1'b0;
    end else begin
      pipe1_q <= pipe1_d;
      pipe2_q <= pipe2_d;
    end
  end

  assign out_q  = pipe1_q;
  assign out_q2 = pipe2_q;

  // Edge pulses decode the two registered stages, so they are glitch-free and exclusive
  assign rise = pipe1_q & ~pipe2_q;
  assign fall = ~pipe1_q & pipe2_q;

`ifdef OR_OP_DOUBLE_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Clear wins over increment; increment stops at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (pipe1_q && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ones_cnt = cnt_q;
`else
  logic unused_cnt_clr;

  assign unused_cnt_clr = cnt_clr;
  assign ones_cnt       = '0;
`endif

endmodule

// File: tb/tb_or_op_double.sv
// Directed bench for or_op_double: truth table, pipeline, edge pulses,
// async reset, counter saturation/clear on a 2-bit and an 8-bit instance.
module tb_or_op_double;

`ifdef OR_OP_DOUBLE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk, rst_n, in0, in1, cnt_clr;
  logic       out_a, out_q_a, out_q2_a, rise_a, fall_a;
  logic [7:0] cnt_a;
  logic       out_b, out_q_b, out_q2_b, rise_b, fall_b;
  logic [1:0] cnt_b;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state
  logic exp_q, exp_q2;
  int   exp_cnt_a, exp_cnt_b;
  int   rise_seen;

  or_op_double #(.CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in0(in0), .in1(in1), .cnt_clr(cnt_clr),
    .out(out_a), .out_q(out_q_a), .out_q2(out_q2_a), .rise(rise_a),
    .fall(fall_a), .ones_cnt(cnt_a)
  );

  or_op_double #(.CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in0(in0), .in1(in1), .cnt_clr(cnt_clr),
    .out(out_b), .out_q(out_q_b), .out_q2(out_q2_b), .rise(rise_b),
    .fall(fall_b), .ones_cnt(cnt_b)
  );

  typedef struct {
    logic in0;
    logic in1;
    logic out;
  } tt_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q     = 1'b0;
    exp_q2    = 1'b0;
    exp_cnt_a = 0;
    exp_cnt_b = 0;
  endtask

  // Full comparison of both instances against the reference state
  task automatic check_all(input string tag);
    chk({tag, ".out_a"},    32'(out_a),    32'(in0 | in1));
    chk({tag, ".out_b"},    32'(out_b),    32'(in0 | in1));
    chk({tag, ".out_q"},    32'(out_q_a),  32'(exp_q));
    chk({tag, ".out_q2"},   32'(out_q2_a), 32'(exp_q2));
    chk({tag, ".rise"},     32'(rise_a),   32'(exp_q & ~exp_q2));
    chk({tag, ".fall"},     32'(fall_a),   32'(~exp_q & exp_q2));
    chk({tag, ".excl"},     32'(rise_a & fall_a), 32'(0));
    chk({tag, ".out_q_b"},  32'(out_q_b),  32'(exp_q));
    chk({tag, ".rise_b"},   32'(rise_b),   32'(exp_q & ~exp_q2));
    chk({tag, ".fall_b"},   32'(fall_b),   32'(~exp_q & exp_q2));
    chk({tag, ".cnt_a"},    32'(cnt_a),    STATS ? 32'(exp_cnt_a) : 32'(0));
    chk({tag, ".cnt_b"},    32'(cnt_b),    STATS ? 32'(exp_cnt_b) : 32'(0));
  endtask

  // One clock cycle: rising edge, falling edge 5 later, sample 1 after that
  task automatic tick(input string tag);
    if (cnt_clr) begin
      exp_cnt_a = 0;
      exp_cnt_b = 0;
    end else if (exp_q) begin
      if (exp_cnt_a < 255) exp_cnt_a++;
      if (exp_cnt_b < 3)   exp_cnt_b++;
    end
    exp_q2 = exp_q;
    exp_q  = in0 | in1;
    clk = 1'b1;
    #5;
    clk = 1'b0;
    #1;
    check_all(tag);
    if (rise_a) rise_seen++;
    #4;
  endtask

  tt_vec_t tt [6];

  initial begin
    tt[0] = '{1'b0, 1'b0, 1'b0};
    tt[1] = '{1'b0, 1'b1, 1'b1};
    tt[2] = '{1'b1, 1'b0, 1'b1};
    tt[3] = '{1'b1, 1'b1, 1'b1};
    tt[4] = '{1'b0, 1'b1, 1'b1};
    tt[5] = '{1'b0, 1'b0, 1'b0};

    clk = 1'b0; rst_n = 1'b0; in0 = 1'b0; in1 = 1'b0; cnt_clr = 1'b0;
    rise_seen = 0;
    model_reset();
    #10;
    check_all("reset");

    // Truth table with clock idle and reset held: out must still follow
    for (int i = 0; i < 6; i++) begin
      in0 = tt[i].in0;
      in1 = tt[i].in1;
      #30;
      chk($sformatf("tt%0d.out", i), 32'(out_a), 32'(tt[i].out));
      chk($sformatf("tt%0d.out_q", i), 32'(out_q_a), 32'(0));
    end

    // Constant-high input at reset release: exactly one rise pulse
    in0 = 1'b1; in1 = 1'b1;
    #2 rst_n = 1'b1;
    #8;
    chk("rel.no_update", 32'(out_q_a), 32'(0));
    tick("rel1");
    chk("rel1.rise_hand", 32'(rise_a), 32'(1));
    tick("rel2");
    chk("rel2.rise_hand", 32'(rise_a), 32'(0));
    chk("rel2.q2_hand", 32'(out_q2_a), 32'(1));
    for (int i = 3; i <= 6; i++) tick($sformatf("rel%0d", i));
    chk("rel.one_rise", 32'(rise_seen), 32'(1));
    chk("sat.cnt_b", 32'(cnt_b), STATS ? 32'(3) : 32'(0));
    chk("sat.cnt_a", 32'(cnt_a), STATS ? 32'(5) : 32'(0));
    tick("sat_hold");
    chk("sat_hold.cnt_b", 32'(cnt_b), STATS ? 32'(3) : 32'(0));

    // Clear while out_q=1 takes priority over increment
    cnt_clr = 1'b1;
    tick("clr");
    chk("clr.cnt_a", 32'(cnt_a), 32'(0));
    chk("clr.cnt_b", 32'(cnt_b), 32'(0));
    cnt_clr = 1'b0;

    // Fall pulse for exactly one cycle, no rise
    in0 = 1'b0; in1 = 1'b0;
    tick("fall1");
    chk("fall1.hand", 32'(fall_a), 32'(1));
    tick("fall2");
    chk("fall2.hand", 32'(fall_a), 32'(0));
    tick("fall3");

    // Pipeline step 0->1
    in1 = 1'b1;
    tick("pipe1");
    chk("pipe1.q_hand", 32'(out_q_a), 32'(1));
    chk("pipe1.q2_hand", 32'(out_q2_a), 32'(0));
    tick("pipe2");
    chk("pipe2.rise_hand", 32'(rise_a), 32'(0));

    // Glitches between edges touch only out
    in1 = 1'b0; #1;
    chk("glitch.out", 32'(out_a), 32'(0));
    chk("glitch.out_q", 32'(out_q_a), 32'(1));
    in1 = 1'b1; #1;
    tick("glitch_after");

    // Build count to 5, then assert reset between edges
    cnt_clr = 1'b1;
    tick("pre5");
    cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++) tick($sformatf("cnt5_%0d", i));
    chk("cnt5.hand", 32'(cnt_a), STATS ? 32'(5) : 32'(0));
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    in1 = 1'b0; in0 = 1'b1; #1;
    chk("async_rst.out10", 32'(out_a), 32'(1));
    in0 = 1'b0; #1;
    chk("async_rst.out00", 32'(out_a), 32'(0));
    #1 rst_n = 1'b1;
    #4;

    // Mixed pattern after reset release
    for (int i = 0; i < 12; i++) begin
      in0 = 1'((i >> 1) & 1);
      in1 = 1'(i % 3 == 0);
      cnt_clr = 1'(i == 7);
      tick($sformatf("mix%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
